// File: rtl/xblock_rf_mt_if.sv
// xblock_rf_mt_if -- bus between the CU/ALU/LSU side and the multi-thread
// register file.
//   master : drives control, decode fields, write data and load returns;
//            receives the read data, rd_valid and busy.
//   slave  : the register file.
// Per-thread vectors are packed [thread][bit], so thread t occupies bits
// [t*DATA_WIDTH +: DATA_WIDTH] of the flattened vector.
interface xblock_rf_mt_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int IMM_WIDTH   = 8
) ();
    localparam int AW = $clog2(NUM_REGS);

    logic                                    rf_enable;
    logic [3:0]                              cu_state;
    logic [DATA_WIDTH-1:0]                   cu_id;
    logic                                    cu_id_load;
    logic [NUM_THREADS-1:0]                  thread_mask;
    logic [AW-1:0]                           decoded_rd;
    logic [AW-1:0]                           decoded_rs1;
    logic [AW-1:0]                           decoded_rs2;
    logic [AW-1:0]                           decoded_rimm;
    logic [IMM_WIDTH-1:0]                    decoded_imm;
    logic                                    is_alu;
    logic                                    is_const;
    logic                                    is_read;
    logic                                    rf_ren;
    logic                                    rf_wen;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  alu_out_data;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  lsu_load_data;
    logic [NUM_THREADS-1:0]                  lsu_load_valid;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  rs1_data;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  rs2_data;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  rimm_data;
    logic                                    rd_valid;
    logic [NUM_THREADS-1:0]                  busy;

    modport master (
        output rf_enable, cu_state, cu_id, cu_id_load, thread_mask,
               decoded_rd, decoded_rs1, decoded_rs2, decoded_rimm, decoded_imm,
               is_alu, is_const, is_read, rf_ren, rf_wen,
               alu_out_data, lsu_load_data, lsu_load_valid,
        input  rs1_data, rs2_data, rimm_data, rd_valid, busy
    );

    modport slave (
        input  rf_enable, cu_state, cu_id, cu_id_load, thread_mask,
               decoded_rd, decoded_rs1, decoded_rs2, decoded_rimm, decoded_imm,
               is_alu, is_const, is_read, rf_ren, rf_wen,
               alu_out_data, lsu_load_data, lsu_load_valid,
        output rs1_data, rs2_data, rimm_data, rd_valid, busy
    );
endinterface

// File: rtl/xblock_rf_mt.sv
// xblock_rf_mt -- per-thread register file for one compute unit.
// Each thread has NUM_REGS registers; the top three are read-only
// (CUIdx, CUWidth, ThreadIdx). Reads in REQ register rs1/rs2/rimm data with
// 1-cycle latency; writebacks in WRITEBACK take ALU > const > load data.
// A load whose data is not ready at writeback is parked (busy/pend_rd) and
// written whenever its data arrives, in any CU state.
// Ports: clk, reset (async, active high), bus (xblock_rf_mt_if.slave).
// Optional feature: define RF_BYPASS_EN to forward a late-load write to a
// same-cycle read of the same register.

module xblock_rf_mt_lane #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int IMM_WIDTH  = 8,
    parameter int CU_WIDTH   = 4,
    parameter int THREAD_ID  = 0,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rf_enable,
    input  logic                  active,
    input  logic                  read_go,
    input  logic                  wb_go,
    input  logic [DATA_WIDTH-1:0] cu_idx,
    input  logic [AW-1:0]         rd,
    input  logic [AW-1:0]         rs1,
    input  logic [AW-1:0]         rs2,
    input  logic [AW-1:0]         rimm,
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic                  is_alu,
    input  logic                  is_const,
    input  logic                  is_read,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  lsu_valid,
    output logic [DATA_WIDTH-1:0] rs1_q,
    output logic [DATA_WIDTH-1:0] rs2_q,
    output logic [DATA_WIDTH-1:0] rimm_q,
    output logic                  busy
);
    localparam int          NW      = NUM_REGS - 3;
    localparam logic [AW-1:0] IDX_CU  = AW'(NUM_REGS - 3);
    localparam logic [AW-1:0] IDX_CW  = AW'(NUM_REGS - 2);

    logic [DATA_WIDTH-1:0] regs [NW];
    logic [AW-1:0]         pend_rd;
    logic                  wb_en, wb_defer, wb_wr, late_en, late_wr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DATA_WIDTH-1:0] rs1_nxt, rs2_nxt, rimm_nxt;

    function automatic logic [DATA_WIDTH-1:0] src(input logic [AW-1:0] a);
        if (a == IDX_CU)      return cu_idx;
        else if (a == IDX_CW) return DATA_WIDTH'(CU_WIDTH);
        else if (a > IDX_CW)  return DATA_WIDTH'(THREAD_ID);
`ifdef RF_BYPASS_EN
        else if (late_wr && a == pend_rd) return lsu_data;
`endif
        else                  return regs[a];
    endfunction

    always_comb begin
        wb_en    = wb_go && active && (is_alu || is_const || is_read);
        // load without data yet: park it instead of writing
        wb_defer = wb_en && !is_alu && !is_const && !lsu_valid;
        wb_wr    = wb_en && !wb_defer && (rd < IDX_CU);
        // the parked load completes regardless of mask; it was issued while active
        late_en  = rf_enable && busy && lsu_valid;
        late_wr  = late_en && (pend_rd < IDX_CU);
        if (is_alu)        wb_data = alu_data;
        else if (is_const) wb_data = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
        else               wb_data = lsu_data;
        rs1_nxt  = src(rs1);
        rs2_nxt  = src(rs2);
        rimm_nxt = src(rimm);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NW; i++) regs[i] <= '0;
            pend_rd <= '0;
            busy    <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rimm_q  <= '0;
        end else begin
            if (late_wr) regs[pend_rd] <= lsu_data;
            // writeback is assigned last so it wins on a same-register collision
            if (wb_wr)   regs[rd] <= wb_data;
            if (wb_defer) begin
                busy    <= 1'b1;
                pend_rd <= rd;
            end else if (late_en) begin
                busy    <= 1'b0;
            end
            if (read_go && active) begin
                rs1_q  <= rs1_nxt;
                rs2_q  <= rs2_nxt;
                rimm_q <= rimm_nxt;
            end
        end
    end
endmodule

module xblock_rf_mt #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int IMM_WIDTH   = 8,
    parameter int CU_IDX      = 0,
    parameter int CU_WIDTH    = 4
) (
    input  logic           clk,
    input  logic           reset,
    xblock_rf_mt_if.slave  bus
);
    localparam int         AW     = $clog2(NUM_REGS);
    localparam logic [3:0] ST_REQ = 4'd3;
    localparam logic [3:0] ST_WB  = 4'd6;

    logic [DATA_WIDTH-1:0] cu_idx;
    logic                  read_go, wb_go;

    assign read_go = bus.rf_enable && bus.cu_state == ST_REQ && bus.rf_ren;
    assign wb_go   = bus.rf_enable && bus.cu_state == ST_WB  && bus.rf_wen;

    // CUIdx is identical in every thread, so one copy serves all lanes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cu_idx       <= DATA_WIDTH'(CU_IDX);
            bus.rd_valid <= 1'b0;
        end else begin
            if (bus.rf_enable && bus.cu_id_load) cu_idx <= bus.cu_id;
            bus.rd_valid <= read_go;
        end
    end

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
        xblock_rf_mt_lane #(
            .NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH), .IMM_WIDTH(IMM_WIDTH),
            .CU_WIDTH(CU_WIDTH), .THREAD_ID(t), .AW(AW)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .rf_enable (bus.rf_enable),
            .active    (bus.thread_mask[t]),
            .read_go   (read_go),
            .wb_go     (wb_go),
            .cu_idx    (cu_idx),
            .rd        (bus.decoded_rd),
            .rs1       (bus.decoded_rs1),
            .rs2       (bus.decoded_rs2),
            .rimm      (bus.decoded_rimm),
            .imm       (bus.decoded_imm),
            .is_alu    (bus.is_alu),
            .is_const  (bus.is_const),
            .is_read   (bus.is_read),
            .alu_data  (bus.alu_out_data[t]),
            .lsu_data  (bus.lsu_load_data[t]),
            .lsu_valid (bus.lsu_load_valid[t]),
            .rs1_q     (bus.rs1_data[t]),
            .rs2_q     (bus.rs2_data[t]),
            .rimm_q    (bus.rimm_data[t]),
            .busy      (bus.busy[t])
        );
    end
endmodule
